// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: command codes, FSM encoding,
// result width and the queued-operation record.
package alu_pkg;

  localparam int RES_W   = 16;
  localparam int OPND_W  = 8;
  localparam int CMD_W   = 4;
  localparam int ENTRY_W = CMD_W + 2 * OPND_W;

  typedef enum logic [CMD_W-1:0] {
    CMD_ADD  = 4'd0,
    CMD_INC  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_DEC  = 4'd3,
    CMD_MUL  = 4'd4,
    CMD_DIV  = 4'd5,
    CMD_SHL  = 4'd6,
    CMD_SHR  = 4'd7,
    CMD_AND  = 4'd8,
    CMD_OR   = 4'd9,
    CMD_INV  = 4'd10,
    CMD_NAND = 4'd11,
    CMD_NOR  = 4'd12,
    CMD_XOR  = 4'd13,
    CMD_XNOR = 4'd14,
    CMD_BUF  = 4'd15
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } issue_state_e;

  // Packed layout matches the FIFO word: {cmd, a, b}
  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } alu_op_t;

  function automatic logic is_div0(alu_op_t op);
    return (op.cmd == CMD_DIV) && (op.b == '0);
  endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// DEPTH-entry synchronous FIFO for queued ALU operations; push/pop are
// ignored when full/empty so the caller may drive them unguarded.
module alu_op_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH is implicit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_issue.sv
// Issue stage in front of the combinational ALU: queues operations, issues one
// at a time, captures the result. Optional ALU_DIV0_TRAP_EN traps DIV by zero.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPND_W-1:0]  in_a,
  input  logic [OPND_W-1:0]  in_b,
  input  logic [CMD_W-1:0]   in_cmd,
  output logic [OPND_W-1:0]  alu_a,
  output logic [OPND_W-1:0]  alu_b,
  output logic [CMD_W-1:0]   alu_cmd,
  output logic               alu_en,
  input  logic [RES_W-1:0]   alu_out,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RES_W-1:0]   res_data,
  output logic [CMD_W-1:0]   res_cmd,
  output logic               busy
`ifdef ALU_DIV0_TRAP_EN
  ,
  output logic               res_err
`endif
);

  issue_state_e state;
  alu_op_t      wr_op;
  alu_op_t      head;
  logic         fifo_full;
  logic         fifo_empty;
  logic [AW:0]  fifo_count;
  logic         push;
  logic         take;
  logic         pop;
  logic         trap;

  assign wr_op    = '{cmd: in_cmd, a: in_a, b: in_b};
  // in_ready follows the registered count only; held low while in reset
  assign in_ready = !fifo_full && !rst;
  assign push     = in_valid && in_ready;
  assign take     = (state == ST_IDLE) || ((state == ST_HOLD) && res_ready);
  assign pop      = take && !fifo_empty;
  assign busy     = (fifo_count != '0) || (state != ST_IDLE);

`ifdef ALU_DIV0_TRAP_EN
  assign trap = is_div0(head);
`else
  assign trap = 1'b0;
`endif

  alu_op_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_op),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cmd   <= '0;
      alu_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cmd   <= '0;
`ifdef ALU_DIV0_TRAP_EN
      res_err   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_HOLD: begin
          if ((state == ST_HOLD) && res_ready) res_valid <= 1'b0;
          if (pop) begin
            if (trap) begin
              // Trapped op never reaches the ALU; result is synthesised here
              res_data  <= '1;
              res_cmd   <= CMD_DIV;
              res_valid <= 1'b1;
`ifdef ALU_DIV0_TRAP_EN
              res_err   <= 1'b1;
`endif
              alu_en    <= 1'b0;
              state     <= ST_HOLD;
            end else begin
              alu_a   <= head.a;
              alu_b   <= head.b;
              alu_cmd <= head.cmd;
              alu_en  <= 1'b1;
              state   <= ST_EXEC;
            end
          end else begin
            alu_en <= 1'b0;
            if ((state == ST_HOLD) && res_ready) state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          res_data  <= alu_out;
          res_cmd   <= alu_cmd;
          res_valid <= 1'b1;
`ifdef ALU_DIV0_TRAP_EN
          res_err   <= 1'b0;
`endif
          alu_en    <= 1'b0;
          state     <= ST_HOLD;
        end
        default: begin
          alu_en <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue with a behavioural ALU on alu_a/alu_b/alu_cmd.
module tb_alu_op_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [3:0]  in_cmd = '0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_en;
  logic [15:0] alu_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [3:0]  res_cmd;
  logic        busy;
`ifdef ALU_DIV0_TRAP_EN
  logic        res_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_op_issue #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cmd    (in_cmd),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cmd   (alu_cmd),
    .alu_en    (alu_en),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cmd   (res_cmd),
    .busy      (busy)
`ifdef ALU_DIV0_TRAP_EN
    ,
    .res_err   (res_err)
`endif
  );

  // Stand-in for the external combinational ALU; DIV by zero returns 16'h0BAD
  always_comb begin
    alu_out = '0;
    case (alu_cmd)
      CMD_ADD:  alu_out = 16'(alu_a) + 16'(alu_b);
      CMD_INC:  alu_out = 16'(alu_a) + 16'd1;
      CMD_SUB:  alu_out = 16'(alu_a) - 16'(alu_b);
      CMD_DEC:  alu_out = 16'(alu_a) - 16'd1;
      CMD_MUL:  alu_out = 16'(alu_a) * 16'(alu_b);
      CMD_DIV:  alu_out = (alu_b == 8'd0) ? 16'h0BAD : 16'(alu_a / alu_b);
      CMD_SHL:  alu_out = 16'(alu_a) << 1;
      CMD_SHR:  alu_out = 16'(alu_a) >> 1;
      CMD_AND:  alu_out = 16'(alu_a & alu_b);
      CMD_OR:   alu_out = 16'(alu_a | alu_b);
      CMD_INV:  alu_out = 16'(~alu_a);
      CMD_NAND: alu_out = 16'(~(alu_a & alu_b));
      CMD_NOR:  alu_out = 16'(~(alu_a | alu_b));
      CMD_XOR:  alu_out = 16'(alu_a ^ alu_b);
      CMD_XNOR: alu_out = 16'(~(alu_a ^ alu_b));
      default:  alu_out = 16'(alu_a);
    endcase
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick;
    tick;
    n_tests++;
    if ({alu_a, alu_b, alu_cmd, alu_en, res_valid, res_data, res_cmd, busy, in_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got a=%h b=%h cmd=%h en=%b rv=%b rd=%h rc=%h busy=%b ir=%b want all 0",
               alu_a, alu_b, alu_cmd, alu_en, res_valid, res_data, res_cmd, busy, in_ready);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_add;
    res_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'd20; in_b = 8'd10; in_cmd = CMD_ADD;
    tick;
    in_valid = 1'b0;
    n_tests++;
    if (alu_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL add_n: got en=%b busy=%b want en=0 busy=1", alu_en, busy);
    end
    tick;
    n_tests++;
    if ({alu_en, alu_a, alu_b, alu_cmd, res_valid} !== {1'b1, 8'd20, 8'd10, CMD_ADD, 1'b0}) begin
      n_fail++; $display("FAIL add_issue: got en=%b a=%0d b=%0d cmd=%0d rv=%b want 1/20/10/0/0",
                         alu_en, alu_a, alu_b, alu_cmd, res_valid);
    end
    tick;
    n_tests++;
    if ({res_valid, res_data, res_cmd, alu_en} !== {1'b1, 16'd30, CMD_ADD, 1'b0}) begin
      n_fail++; $display("FAIL add_result: got rv=%b data=%0d cmd=%0d en=%b want 1/30/0/0",
                         res_valid, res_data, res_cmd, alu_en);
    end
    tick;
    n_tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL add_done: got rv=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_hold_stable;
    res_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'd25; in_b = 8'd17; in_cmd = CMD_AND;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({res_valid, res_data, res_cmd, alu_en} !== {1'b1, 16'd17, CMD_AND, 1'b0}) begin
        n_fail++; $display("FAIL and_hold[%0d]: got rv=%b data=%0d cmd=%0d en=%b want 1/17/8/0",
                           i, res_valid, res_data, res_cmd, alu_en);
      end
      tick;
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0) begin n_fail++; $display("FAIL and_release: got rv=%b want 0", res_valid); end
    tick;
    n_tests++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL and_single: got rv=%b busy=%b want 0/0", res_valid, busy);
    end
  endtask

  task automatic test_fill;
    int accepted;
    int got;
    accepted = 0;
    got = 0;
    res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = 8'(50 + i); in_b = 8'd8; in_cmd = CMD_SUB;
      if (in_ready) accepted++;
      tick;
    end
    in_valid = 1'b0;
    n_tests++;
    if (accepted != 5) begin n_fail++; $display("FAIL fill_accepted: got %0d want 5", accepted); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready[%0d]: got %b want 0", i, in_ready); end
      tick;
    end
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (res_valid) begin
        n_tests++;
        if (res_data !== 16'(42 + got) || res_cmd !== CMD_SUB) begin
          n_fail++; $display("FAIL fill_result[%0d]: got data=%0d cmd=%0d want %0d/2",
                             got, res_data, res_cmd, 42 + got);
        end
        got++;
      end
      tick;
    end
    n_tests++;
    if (got != 5) begin n_fail++; $display("FAIL fill_count: got %0d results want 5", got); end
    tick;
    n_tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL fill_idle: got busy=%b rv=%b want 0/0", busy, res_valid);
    end
    res_ready = 1'b0;
  endtask

  task automatic test_push_pop_full;
    logic [3:0]  op_cmd [6];
    logic [7:0]  op_a   [6];
    logic [7:0]  op_b   [6];
    logic [15:0] op_exp [6];
    logic [15:0] sb [$];
    logic [15:0] want;
    int idx;
    int got;
    op_cmd = '{CMD_OR, CMD_XOR, CMD_MUL, CMD_INC, CMD_SHL, CMD_ADD};
    op_a   = '{8'h0F, 8'hAA, 8'd12, 8'd7, 8'h81, 8'd255};
    op_b   = '{8'hF0, 8'h0F, 8'd12, 8'd0, 8'd0, 8'd1};
    op_exp = '{16'h00FF, 16'h00A5, 16'd144, 16'd8, 16'h0102, 16'h0100};
    idx = 0;
    got = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      in_valid  = (idx < 6);
      in_a      = op_a[idx % 6];
      in_b      = op_b[idx % 6];
      in_cmd    = op_cmd[idx % 6];
      res_ready = (cyc >= 6);
      if (cyc == 6) begin
        n_tests++;
        if (in_ready !== 1'b0 || idx != 5) begin
          n_fail++; $display("FAIL full_refuse: got in_ready=%b pushed=%0d want 0/5", in_ready, idx);
        end
      end
      if (cyc == 7) begin
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_retry: got in_ready=%b want 1", in_ready); end
      end
      if (res_valid && res_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL full_extra: got data=%h want no result", res_data);
        end else begin
          want = sb.pop_front();
          if (res_data !== want) begin
            n_fail++; $display("FAIL full_order[%0d]: got %h want %h", got, res_data, want);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(op_exp[idx]);
        idx++;
      end
      tick;
    end
    in_valid = 1'b0;
    res_ready = 1'b0;
    n_tests++;
    if (got != 6 || sb.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL full_total: got results=%0d left=%0d busy=%b want 6/0/0", got, sb.size(), busy);
    end
  endtask

  task automatic test_reset_mid;
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = 8'(i + 1); in_b = 8'd0; in_cmd = CMD_BUF;
      tick;
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    n_tests++;
    if (alu_en !== 1'b1 || alu_a !== 8'd2) begin
      n_fail++; $display("FAIL mid_exec: got en=%b a=%0d want 1/2", alu_en, alu_a);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({alu_a, alu_b, alu_cmd, alu_en, res_valid, res_data, res_cmd, busy, in_ready} !== '0) begin
      n_fail++; $display("FAIL mid_async: got a=%h en=%b rv=%b rd=%h busy=%b ir=%b want all 0",
                         alu_a, alu_en, res_valid, res_data, busy, in_ready);
    end
    tick;
    tick;
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_release: got in_ready=%b busy=%b want 1/0", in_ready, busy);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      n_tests++;
      if (res_valid !== 1'b0 || alu_en !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale[%0d]: got rv=%b en=%b want 0/0", i, res_valid, alu_en);
      end
    end
    res_ready = 1'b0;
  endtask

  task automatic test_div0;
    res_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'd40; in_b = 8'd0; in_cmd = CMD_DIV;
    tick;
    in_valid = 1'b0;
`ifdef ALU_DIV0_TRAP_EN
    tick;
    n_tests++;
    if ({alu_en, res_valid, res_data, res_cmd, res_err} !== {1'b0, 1'b1, 16'hFFFF, CMD_DIV, 1'b1}) begin
      n_fail++; $display("FAIL div0_trap: got en=%b rv=%b data=%h cmd=%0d err=%b want 0/1/ffff/5/1",
                         alu_en, res_valid, res_data, res_cmd, res_err);
    end
    tick;
    n_tests++;
    if (alu_en !== 1'b0 || res_valid !== 1'b1) begin
      n_fail++; $display("FAIL div0_hold: got en=%b rv=%b want 0/1", alu_en, res_valid);
    end
    res_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'd40; in_b = 8'd8; in_cmd = CMD_DIV;
    tick;
    in_valid = 1'b0;
    n_tests++;
    if (res_valid !== 1'b0 || alu_en !== 1'b0) begin
      n_fail++; $display("FAIL div_consume: got rv=%b en=%b want 0/0", res_valid, alu_en);
    end
    tick;
    n_tests++;
    if (alu_en !== 1'b1 || alu_b !== 8'd8) begin
      n_fail++; $display("FAIL div_issue: got en=%b b=%0d want 1/8", alu_en, alu_b);
    end
    tick;
    n_tests++;
    if ({res_valid, res_data, res_cmd, res_err} !== {1'b1, 16'd5, CMD_DIV, 1'b0}) begin
      n_fail++; $display("FAIL div_result: got rv=%b data=%0d cmd=%0d err=%b want 1/5/5/0",
                         res_valid, res_data, res_cmd, res_err);
    end
`else
    tick;
    n_tests++;
    if (alu_en !== 1'b1 || alu_b !== 8'd0 || alu_cmd !== CMD_DIV) begin
      n_fail++; $display("FAIL div0_issue: got en=%b b=%0d cmd=%0d want 1/0/5", alu_en, alu_b, alu_cmd);
    end
    tick;
    n_tests++;
    if ({res_valid, res_data, res_cmd} !== {1'b1, 16'h0BAD, CMD_DIV}) begin
      n_fail++; $display("FAIL div0_pass: got rv=%b data=%h cmd=%0d want 1/0bad/5", res_valid, res_data, res_cmd);
    end
    res_ready = 1'b1;
`endif
    tick;
    res_ready = 1'b0;
    tick;
    n_tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL div_idle: got busy=%b rv=%b want 0/0", busy, res_valid);
    end
  endtask

  initial begin
    test_reset;
    test_single_add;
    test_hold_stable;
    test_fill;
    test_push_pop_full;
    test_reset_mid;
    test_div0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
